hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the five-stage RISC-V core. It combines operand forwarding selection for the execute stage with stall, bubble and flush generation. The hazards it covers are load-use, taken branches, and a multi-cycle execute unit (mul/div) busy handshake. It also keeps a saturating stall-cycle counter. It sits beside the pipeline registers and drives their hold/clear controls and the execute-stage operand muxes.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_forward_sel.sv | 40 ++++
 rtl/hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - forward select encodings driven onto the execute-stage operand muxes
//   - FSM state enum for the stall sequencer
//   - packed bundle of the pipeline-register control outputs
package hazard_pkg;

    localparam logic [1:0] RS_DATA = 2'b00;  // operand from register file
    localparam logic [1:0] FW_MEM  = 2'b01;  // operand from EX/MEM result
    localparam logic [1:0] FW_WB   = 2'b10;  // operand from MEM/WB result

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MC_WAIT    = 2'd2
    } state_t;

    typedef struct packed {
        logic stall_fetch;
        logic stall_decode;
        logic stall_execute;
        logic bubble_execute;
        logic bubble_mem;
        logic flush_decode;
        logic flush_execute;
        logic mc_busy;
    } ctrl_t;

endpackage

// File: rtl/hazard_forward_sel.sv
// hazard_forward_sel: forwarding select for one execute-stage source operand.
// Ports:
//   src_addr               in   execute-stage source register address
//   rd_addr_mem/_write_mem in   destination of the instruction in MEM
//   rd_addr_wb/_write_wb   in   destination of the instruction in WB
//   sel                    out  RS_DATA / FW_MEM / FW_WB
// MEM wins over WB because it holds the younger write. x0 never forwards.
module hazard_forward_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit WB_FORWARD = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr_mem,
    input  logic                  rd_write_mem,
    input  logic [REG_ADDR_W-1:0] rd_addr_wb,
    input  logic                  rd_write_wb,
    output logic [1:0]            sel
);

    logic src_nz;
    logic mem_hit;
    logic wb_hit;

    assign src_nz  = (src_addr != '0);
    assign mem_hit = src_nz && rd_write_mem && (src_addr == rd_addr_mem);
    // With WB forwarding off the register file writes through, so the
    // plain read already carries the WB value.
    assign wb_hit  = WB_FORWARD && src_nz && rd_write_wb && (src_addr == rd_addr_wb);

    always_comb begin
        sel = RS_DATA;
        if (mem_hit)
            sel = FW_MEM;
        else if (wb_hit)
            sel = FW_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline hazard controller.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   rs*_addr_decode / rs*_use_decode decode-stage sources (load-use check)
//   rs*_addr_execute                 execute-stage sources (forwarding)
//   rd_addr/_write/mem_read_execute  instruction in execute
//   rd_addr/_write_mem, _wb          instructions in MEM and WB
//   branch_taken_execute             redirect resolved in execute
//   mc_start_execute, mc_done        multi-cycle unit handshake
//   forward_control_src1/src2        execute operand mux selects
//   stall_*, bubble_*, flush_*       pipeline register hold/clear controls
//   mc_busy                          waiting on the multi-cycle unit
//   stall_count                      saturating count of stall_fetch cycles
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W       = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter bit WB_FORWARD       = 1'b1,
    parameter int CNT_W            = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_addr_decode,
    input  logic [REG_ADDR_W-1:0] rs2_addr_decode,
    input  logic                  rs1_use_decode,
    input  logic                  rs2_use_decode,
    input  logic [REG_ADDR_W-1:0] rs1_addr_execute,
    input  logic [REG_ADDR_W-1:0] rs2_addr_execute,
    input  logic [REG_ADDR_W-1:0] rd_addr_execute,
    input  logic                  rd_write_execute,
    input  logic                  mem_read_execute,
    input  logic [REG_ADDR_W-1:0] rd_addr_mem,
    input  logic                  rd_write_mem,
    input  logic [REG_ADDR_W-1:0] rd_addr_wb,
    input  logic                  rd_write_wb,
    input  logic                  branch_taken_execute,
    input  logic                  mc_start_execute,
    input  logic                  mc_done,
    output logic [1:0]            forward_control_src1,
    output logic [1:0]            forward_control_src2,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic                  stall_execute,
    output logic                  bubble_execute,
    output logic                  bubble_mem,
    output logic                  flush_decode,
    output logic                  flush_execute,
    output logic                  mc_busy,
    output logic [CNT_W-1:0]      stall_count
);

    // Remaining bubbles after the detection cycle; unused when only one
    // bubble is inserted.
    localparam logic [1:0] LUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

    // ---------------------------------------------------------------
    // Forwarding
    // ---------------------------------------------------------------
    logic [1:0] sel1;
    logic [1:0] sel2;

    hazard_forward_sel #(
        .REG_ADDR_W (REG_ADDR_W),
        .WB_FORWARD (WB_FORWARD)
    ) u_fwd_src1 (
        .src_addr     (rs1_addr_execute),
        .rd_addr_mem  (rd_addr_mem),
        .rd_write_mem (rd_write_mem),
        .rd_addr_wb   (rd_addr_wb),
        .rd_write_wb  (rd_write_wb),
        .sel          (sel1)
    );

    hazard_forward_sel #(
        .REG_ADDR_W (REG_ADDR_W),
        .WB_FORWARD (WB_FORWARD)
    ) u_fwd_src2 (
        .src_addr     (rs2_addr_execute),
        .rd_addr_mem  (rd_addr_mem),
        .rd_write_mem (rd_write_mem),
        .rd_addr_wb   (rd_addr_wb),
        .rd_write_wb  (rd_write_wb),
        .sel          (sel2)
    );

    assign forward_control_src1 = rst ? RS_DATA : sel1;
    assign forward_control_src2 = rst ? RS_DATA : sel2;

    // ---------------------------------------------------------------
    // Stall sequencer
    // ---------------------------------------------------------------
    state_t     state, state_next;
    logic [1:0] bub_cnt, bub_cnt_next;
    ctrl_t      ctrl;
    logic       load_use;

    assign load_use = mem_read_execute && rd_write_execute && (rd_addr_execute != '0) &&
                      ((rs1_use_decode && (rs1_addr_decode == rd_addr_execute)) ||
                       (rs2_use_decode && (rs2_addr_decode == rd_addr_execute)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            bub_cnt <= 2'd0;
        end else begin
            state   <= state_next;
            bub_cnt <= bub_cnt_next;
        end
    end

    always_comb begin
        ctrl         = '0;
        state_next   = state;
        bub_cnt_next = bub_cnt;
        case (state)
            RUN: begin
                if (branch_taken_execute) begin
                    // Wrong-path instructions are killed; whatever hazard
                    // they carried goes with them.
                    ctrl.flush_decode  = 1'b1;
                    ctrl.flush_execute = 1'b1;
                end else if (mc_start_execute) begin
                    ctrl.stall_fetch   = 1'b1;
                    ctrl.stall_decode  = 1'b1;
                    ctrl.stall_execute = 1'b1;
                    ctrl.bubble_mem    = 1'b1;
                    state_next         = MC_WAIT;
                end else if (load_use) begin
                    ctrl.stall_fetch    = 1'b1;
                    ctrl.stall_decode   = 1'b1;
                    ctrl.bubble_execute = 1'b1;
                    if (LOAD_USE_BUBBLES > 1) begin
                        bub_cnt_next = LUB_INIT;
                        state_next   = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                // Execute holds a bubble, so branch/mc inputs are not real.
                ctrl.stall_fetch    = 1'b1;
                ctrl.stall_decode   = 1'b1;
                ctrl.bubble_execute = 1'b1;
                bub_cnt_next        = bub_cnt - 2'd1;
                if (bub_cnt <= 2'd1)
                    state_next = RUN;
            end
            MC_WAIT: begin
                ctrl.mc_busy = 1'b1;
                if (mc_done) begin
                    state_next = RUN;
                end else begin
                    ctrl.stall_fetch   = 1'b1;
                    ctrl.stall_decode  = 1'b1;
                    ctrl.stall_execute = 1'b1;
                    ctrl.bubble_mem    = 1'b1;
                end
            end
            default: begin
                state_next   = RUN;
                bub_cnt_next = 2'd0;
            end
        endcase
        if (rst)
            ctrl = '0;
    end

    assign stall_fetch    = ctrl.stall_fetch;
    assign stall_decode   = ctrl.stall_decode;
    assign stall_execute  = ctrl.stall_execute;
    assign bubble_execute = ctrl.bubble_execute;
    assign bubble_mem     = ctrl.bubble_mem;
    assign flush_decode   = ctrl.flush_decode;
    assign flush_execute  = ctrl.flush_execute;
    assign mc_busy        = ctrl.mc_busy;

    // ---------------------------------------------------------------
    // Saturating stall-cycle counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (ctrl.stall_fetch && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameter variants share one stimulus stream.
//   inst 0: LOAD_USE_BUBBLES=2, WB_FORWARD=1, CNT_W=32
//   inst 1: LOAD_USE_BUBBLES=1, WB_FORWARD=0, CNT_W=32
//   inst 2: LOAD_USE_BUBBLES=4, WB_FORWARD=1, CNT_W=3 (saturation)
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       u1, u2, rdwe, mrd, wm, ww, br, mcs, mcd;

    logic [1:0] src1 [3];
    logic [1:0] src2 [3];
    logic sf [3], sd [3], se [3], be [3], bm [3], fd [3], fe [3], busy [3];
    logic [31:0] cnt0, cnt1;
    logic [2:0]  cnt2;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(2), .WB_FORWARD(1'b1), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst),
        .rs1_addr_decode(rs1d), .rs2_addr_decode(rs2d), .rs1_use_decode(u1), .rs2_use_decode(u2),
        .rs1_addr_execute(rs1e), .rs2_addr_execute(rs2e), .rd_addr_execute(rde),
        .rd_write_execute(rdwe), .mem_read_execute(mrd),
        .rd_addr_mem(rdm), .rd_write_mem(wm), .rd_addr_wb(rdw), .rd_write_wb(ww),
        .branch_taken_execute(br), .mc_start_execute(mcs), .mc_done(mcd),
        .forward_control_src1(src1[0]), .forward_control_src2(src2[0]),
        .stall_fetch(sf[0]), .stall_decode(sd[0]), .stall_execute(se[0]),
        .bubble_execute(be[0]), .bubble_mem(bm[0]),
        .flush_decode(fd[0]), .flush_execute(fe[0]), .mc_busy(busy[0]), .stall_count(cnt0));

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(1), .WB_FORWARD(1'b0), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst),
        .rs1_addr_decode(rs1d), .rs2_addr_decode(rs2d), .rs1_use_decode(u1), .rs2_use_decode(u2),
        .rs1_addr_execute(rs1e), .rs2_addr_execute(rs2e), .rd_addr_execute(rde),
        .rd_write_execute(rdwe), .mem_read_execute(mrd),
        .rd_addr_mem(rdm), .rd_write_mem(wm), .rd_addr_wb(rdw), .rd_write_wb(ww),
        .branch_taken_execute(br), .mc_start_execute(mcs), .mc_done(mcd),
        .forward_control_src1(src1[1]), .forward_control_src2(src2[1]),
        .stall_fetch(sf[1]), .stall_decode(sd[1]), .stall_execute(se[1]),
        .bubble_execute(be[1]), .bubble_mem(bm[1]),
        .flush_decode(fd[1]), .flush_execute(fe[1]), .mc_busy(busy[1]), .stall_count(cnt1));

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(4), .WB_FORWARD(1'b1), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst),
        .rs1_addr_decode(rs1d), .rs2_addr_decode(rs2d), .rs1_use_decode(u1), .rs2_use_decode(u2),
        .rs1_addr_execute(rs1e), .rs2_addr_execute(rs2e), .rd_addr_execute(rde),
        .rd_write_execute(rdwe), .mem_read_execute(mrd),
        .rd_addr_mem(rdm), .rd_write_mem(wm), .rd_addr_wb(rdw), .rd_write_wb(ww),
        .branch_taken_execute(br), .mc_start_execute(mcs), .mc_done(mcd),
        .forward_control_src1(src1[2]), .forward_control_src2(src2[2]),
        .stall_fetch(sf[2]), .stall_decode(sd[2]), .stall_execute(se[2]),
        .bubble_execute(be[2]), .bubble_mem(bm[2]),
        .flush_decode(fd[2]), .flush_execute(fe[2]), .mc_busy(busy[2]), .stall_count(cnt2));

    // ---------------- reference model ----------------
    int  lub [3]    = '{2, 1, 4};
    bit  wbf [3]    = '{1'b1, 1'b0, 1'b1};
    longint cmax[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};
    int     ls_rem [3];   // load-use stall cycles still owed after this one
    bit     mc_wait [3];  // waiting on multi-cycle result
    longint scnt [3];
    bit     synced = 1'b0;

    function automatic logic [1:0] fwd_exp(logic [4:0] a, bit wbon);
        if (rst || a == 5'd0)        return 2'b00;
        if (wm && a == rdm)          return 2'b01;
        if (wbon && ww && a == rdw)  return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit lu_hit();
        return mrd && rdwe && rde != 5'd0 &&
               ((u1 && rs1d == rde) || (u2 && rs2d == rde));
    endfunction

    // {src1, src2, sf, sd, se, be, bm, fd, fe, busy}
    function automatic logic [11:0] exp_ctl(int i);
        logic s_f = 0, s_d = 0, s_e = 0, b_e = 0, b_m = 0, f_d = 0, f_e = 0, bz = 0;
        if (!rst) begin
            if (ls_rem[i] > 0) begin
                s_f = 1; s_d = 1; b_e = 1;
            end else if (mc_wait[i]) begin
                bz = 1;
                if (!mcd) begin s_f = 1; s_d = 1; s_e = 1; b_m = 1; end
            end else if (br) begin
                f_d = 1; f_e = 1;
            end else if (mcs) begin
                s_f = 1; s_d = 1; s_e = 1; b_m = 1;
            end else if (lu_hit()) begin
                s_f = 1; s_d = 1; b_e = 1;
            end
        end
        return {fwd_exp(rs1e, wbf[i]), fwd_exp(rs2e, wbf[i]), s_f, s_d, s_e, b_e, b_m, f_d, f_e, bz};
    endfunction

    function automatic logic [11:0] act_ctl(int i);
        return {src1[i], src2[i], sf[i], sd[i], se[i], be[i], bm[i], fd[i], fe[i], busy[i]};
    endfunction

    function automatic logic [31:0] act_cnt(int i);
        if (i == 0) return cnt0;
        if (i == 1) return cnt1;
        return {29'd0, cnt2};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [11:0] e;
            e = exp_ctl(i);
            if (rst) begin
                ls_rem[i] = 0; mc_wait[i] = 0; scnt[i] = 0;
            end else begin
                if (e[7] && scnt[i] < cmax[i]) scnt[i] = scnt[i] + 1;
                if (ls_rem[i] > 0)         ls_rem[i] = ls_rem[i] - 1;
                else if (mc_wait[i])       mc_wait[i] = !mcd;
                else if (br)               ;
                else if (mcs)              mc_wait[i] = 1;
                else if (lu_hit())         ls_rem[i] = lub[i] - 1;
            end
        end
        if (rst) synced = 1'b1;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle, every instance
    always @(negedge clk) begin
        if (synced) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("ctl[%0d]", i), {20'd0, act_ctl(i)}, {20'd0, exp_ctl(i)});
                chk($sformatf("stall_count[%0d]", i), act_cnt(i), scnt[i][31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_in();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        u1 = 0; u2 = 0; rdwe = 0; mrd = 0; wm = 0; ww = 0; br = 0; mcs = 0; mcd = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_load_use();
        mrd = 1; rdwe = 1; rde = 5'd7; rs2d = 5'd7; u2 = 1;
    endtask

    task automatic rand_in();
        rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
        rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
        rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
        rdw  = 5'($urandom_range(0, 3));
        u1 = 1'($urandom); u2 = 1'($urandom); rdwe = 1'($urandom); wm = 1'($urandom); ww = 1'($urandom);
        mrd = ($urandom_range(0, 9) < 4);
        br  = ($urandom_range(0, 9) == 0);
        mcs = ($urandom_range(0, 9) == 0);
        mcd = ($urandom_range(0, 9) < 3);
        rst = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        idle_in();
        rst = 1;
        // reset forces outputs low even with hazards on the inputs
        step();
        mcs = 1; rs1e = 5; rdm = 5; wm = 1; #1;
        chk("rst_stall_execute", {31'd0, se[0]}, 0);
        chk("rst_stall_fetch", {31'd0, sf[0]}, 0);
        chk("rst_src1", {30'd0, src1[0]}, 0);
        step(); idle_in(); #1;
        chk("rst_count", cnt0, 0);

        // forwarding priority and x0 guard
        step(); rst = 0;
        rs1e = 5; rdm = 5; wm = 1; rdw = 5; ww = 1; #1;
        chk("fwd_mem_prio", {30'd0, src1[0]}, 1);
        wm = 0; #1;
        chk("fwd_wb", {30'd0, src1[0]}, 2);
        rs1e = 9; rdw = 9; #1;
        chk("fwd_wb_off", {30'd0, src1[1]}, 0);
        chk("fwd_wb_on", {30'd0, src1[0]}, 2);
        rs2e = 0; rdm = 0; wm = 1; #1;
        chk("fwd_x0", {30'd0, src2[0]}, 0);

        // load-use, two bubbles on inst 0
        step(); idle_in(); set_load_use(); #1;
        chk("lu_c0_stall", {29'd0, sf[0], sd[0], be[0]}, 7);
        step(); idle_in(); #1;
        chk("lu_c1_stall", {29'd0, sf[0], sd[0], be[0]}, 7);
        chk("lu_c1_single", {31'd0, sf[1]}, 0);
        step(); #1;
        chk("lu_c2_free", {29'd0, sf[0], sd[0], be[0]}, 0);
        chk("lu_count", cnt0, 2);
        chk("lu_count1", cnt1, 1);
        repeat (3) step();
        chk("lu_count4", {29'd0, cnt2}, 4);

        // branch beats load-use
        step(); set_load_use(); br = 1; #1;
        chk("br_flush", {30'd0, fd[0], fe[0]}, 3);
        chk("br_nostall", {31'd0, sf[0]}, 0);
        step(); idle_in(); #1;
        chk("br_flush_off", {30'd0, fd[0], fe[0]}, 0);
        chk("br_count", cnt0, 2);

        // multi-cycle: start at c0, done at c3
        step(); mcs = 1; #1;
        chk("mc_c0", {28'd0, se[0], bm[0], sf[0], busy[0]}, 4'b1110);
        step(); mcs = 0; #1;
        chk("mc_c1", {28'd0, se[0], bm[0], sf[0], busy[0]}, 4'b1111);
        step(); #1;
        chk("mc_c2", {28'd0, se[0], bm[0], sf[0], busy[0]}, 4'b1111);
        step(); mcd = 1; #1;
        chk("mc_c3", {28'd0, se[0], bm[0], sf[0], busy[0]}, 4'b0001);
        step(); mcd = 0; #1;
        chk("mc_after", {31'd0, busy[0]}, 0);
        chk("mc_count", cnt0, 5);

        // reset in the middle of MC_WAIT
        step(); mcs = 1;
        step(); mcs = 0;
        step(); rst = 1; rs1e = 5; rdm = 5; wm = 1; #1;
        chk("mcrst_ctl", {20'd0, act_ctl(0)}, 0);
        step(); idle_in(); rst = 0; #1;
        chk("mcrst_count", cnt0, 0);
        mcd = 1; #1;
        chk("mcrst_done_ignored", {28'd0, se[0], bm[0], sf[0], busy[0]}, 0);
        step(); mcd = 0; #1;
        chk("mcrst_count2", cnt0, 0);

        // long multi-cycle wait saturates the 3-bit counter
        step(); mcs = 1;
        step(); mcs = 0;
        repeat (10) step();
        chk("sat_count0", cnt0, 11);
        chk("sat_count2", {29'd0, cnt2}, 7);
        mcd = 1;
        step(); mcd = 0;

        // randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            step();
            rand_in();
        end
        step(); idle_in(); rst = 1;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
